ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the register operands delivered by the ID/EX pipeline register and executes MULT, MULTU, DIV and DIVU over 32 iteration cycles. While busy it requests a pipeline stall, and it owns the architectural HI/LO registers used by MFHI, MFLO, MTHI and MTLO.

## Interface
Parameters:
- none; width fixed at 32 bits, iteration count fixed at 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  EX holds a mul/div instruction; held high by the pipeline while stalled
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  32  operand A (dividend / multiplicand), from ex_rdata1 after forwarding
- rt_val  in  32  operand B (divisor / multiplier), from ex_rdata2 after forwarding
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- flush  in  1  abort the current operation (exception or redirect)
- stall_req  out  1  freeze IF/ID/EX; combinational
- busy  out  1  state != IDLE; registered
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with start=1:
  - latch |rs_val| and |rt_val|; signed ops only, unsigned ops latch operands raw
  - latch the result sign flags and op
  - clear cnt to 0; go to CALC
- CALC performs one radix-2 step per cycle:
  - multiply: shift-add into a 64-bit accumulator
  - divide: restoring subtract-shift, 64-bit remainder/quotient register
  - cnt increments; at cnt==31 go to DONE
- DONE:
  - apply sign correction: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA
  - write HI/LO: multiply gives {HI,LO} = 64-bit product; divide gives LO = quotient, HI = remainder
  - go to IDLE unconditionally; start is ignored in DONE
- Divide by zero (rt_val==0 latched): full latency, then HI=rs_val, LO=32'hFFFFFFFF for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- hi_we/lo_we:
  - honoured only in IDLE with start=0; write takes effect at that edge
  - ignored in CALC and DONE
  - start has priority over hi_we/lo_we
- flush: from any state go to IDLE at the next edge; HI/LO are not written. flush in DONE suppresses the HI/LO write.
- rst: state=IDLE, cnt=0, hi=0, lo=0, busy=0, stall_req=0; operand/accumulator registers cleared.

## Timing
- stall_req = (state==IDLE & start & ~flush) | (state==CALC & ~flush); low in DONE, so the instruction leaves EX at the end of the DONE cycle.
- Occupancy: 1 IDLE + 32 CALC + 1 DONE = 34 cycles in EX; stall_req high for exactly 33 consecutive cycles.
- HI/LO visible on the outputs the cycle after DONE, so an MFHI/MFLO directly following reads the new value without an extra hazard.
- Back-to-back mul/div: the second start is seen in IDLE one cycle after DONE; no idle gap beyond that cycle.
- Reset asserted mid-CALC: next cycle in IDLE, HI/LO=0, stall_req=0.

## Structure
- Shared header definations.vh gets:
  - md_op_mult/multu/div/divu encodings
  - md_state_idle/calc/done
  - md_iter = 32
- The ID decoder uses the same op encodings.
- No sub-module: the shared shift datapath, sign fix and FSM stay in one file.
- HI/LO live here, not in the register file.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; stall_req high 33 cycles, HI/LO updated on the 34th edge.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → HI=100, LO=0xFFFFFFFF after full 34-cycle occupancy; DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- MTHI 0x12345678 in IDLE → hi=0x12345678 next cycle; MTLO asserted during CALC → ignored, LO gets the mul/div result.
- flush at CALC cycle 10 of DIVU 9/2 (HI/LO preloaded 0xA/0xB) → IDLE next cycle, stall_req low, HI/LO stay 0xA/0xB; flush in DONE → no write.
- rst mid-CALC → hi=lo=0, busy=0; then two back-to-back MULTU 3×5 and 4×6 → LO=15, then LO=24, second stall begins the cycle after the first DONE.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation and
// state encodings, iteration count and small arithmetic helpers.
package ex_muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;

    // Last value of the iteration counter before leaving CALC.
    localparam logic [4:0] MD_LAST_CNT = 5'd31;

    // Operation encodings, shared with the ID decoder.
    typedef enum logic [1:0] {
        md_op_mult  = 2'b00,
        md_op_multu = 2'b01,
        md_op_div   = 2'b10,
        md_op_divu  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        md_state_idle = 2'b00,
        md_state_calc = 2'b01,
        md_state_done = 2'b10
    } md_state_e;

    // Two's complement negation of a 32-bit word.
    function automatic logic [31:0] md_neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Two's complement negation of a 64-bit word.
    function automatic logic [63:0] md_neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // True for the signed flavours (MULT, DIV).
    function automatic logic md_is_signed(input md_op_e o);
        return (o == md_op_mult) || (o == md_op_div);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit for the EX stage. One radix-2 step
// per cycle over 32 cycles, stalls the pipeline while working and owns the
// architectural HI/LO registers.
import ex_muldiv_pkg::*;

module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // FSM and control state
    md_state_e   state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;

    // Shared datapath: acc holds {partial product, multiplier} for multiply
    // and {remainder, dividend/quotient} for divide. addend is the
    // multiplicand or the divisor, both as magnitudes.
    logic [63:0] acc_reg, acc_next;
    logic [31:0] addend_reg, addend_next;
    logic [31:0] rs_raw_reg, rs_raw_next;
    logic        is_div_reg, is_div_next;
    logic        neg_res_reg, neg_res_next;   // sign of product / quotient
    logic        neg_rem_reg, neg_rem_next;   // sign of remainder
    logic        div0_reg, div0_next;

    // Architectural HI/LO
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    // Operand decode for the cycle the instruction is accepted
    md_op_e      op_e;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // One multiply step
    logic [31:0] mul_addend;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;

    // One restoring divide step
    logic [32:0] div_rem_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_step;

    // Sign-corrected results
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign op_e   = md_op_e'(op);
    assign sign_a = md_is_signed(op_e) & rs_val[31];
    assign sign_b = md_is_signed(op_e) & rt_val[31];
    assign mag_a  = sign_a ? md_neg32(rs_val) : rs_val;
    assign mag_b  = sign_b ? md_neg32(rt_val) : rt_val;

    // Multiplicand gated by the current multiplier LSB, bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < MD_WIDTH; gi++) begin : g_mul_gate
            assign mul_addend[gi] = addend_reg[gi] & acc_reg[0];
        end
    endgenerate

    // Shift-add: add into the upper half, then shift the whole accumulator
    // right so the carry lands in bit 63 and the used multiplier bit drops.
    assign mul_sum  = {1'b0, acc_reg[63:32]} + {1'b0, mul_addend};
    assign mul_step = {mul_sum, acc_reg[31:1]};

    // Restoring divide: shift remainder left pulling in the next dividend
    // bit, subtract the divisor if it fits, shift the quotient bit in at 0.
    // The shifted remainder needs 33 bits; the result always fits 32.
    assign div_rem_shift = acc_reg[63:31];
    assign div_diff      = div_rem_shift - {1'b0, addend_reg};
    assign div_ge        = (div_rem_shift >= {1'b0, addend_reg});
    assign div_step      = div_ge ? {div_diff[31:0], acc_reg[30:0], 1'b1}
                                  : {div_rem_shift[31:0], acc_reg[30:0], 1'b0};

    assign prod_fix = neg_res_reg ? md_neg64(acc_reg) : acc_reg;
    assign quo_fix  = neg_res_reg ? md_neg32(acc_reg[31:0]) : acc_reg[31:0];
    assign rem_fix  = neg_rem_reg ? md_neg32(acc_reg[63:32]) : acc_reg[63:32];

    // Next-state, datapath and HI/LO update logic
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        addend_next  = addend_reg;
        rs_raw_next  = rs_raw_reg;
        is_div_next  = is_div_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        div0_next    = div0_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;

        case (state_reg)
            md_state_idle: begin
                if (flush) begin
                    // Instruction in EX is being killed: accept nothing.
                    state_next = md_state_idle;
                end else if (start) begin
                    state_next   = md_state_calc;
                    cnt_next     = 5'd0;
                    is_div_next  = op[1];
                    addend_next  = op[1] ? mag_b : mag_a;
                    acc_next     = {32'd0, (op[1] ? mag_a : mag_b)};
                    rs_raw_next  = rs_val;
                    neg_res_next = sign_a ^ sign_b;
                    neg_rem_next = sign_a;
                    div0_next    = op[1] && (rt_val == 32'd0);
                end else begin
                    if (hi_we) hi_next = wdata;
                    if (lo_we) lo_next = wdata;
                end
            end

            md_state_calc: begin
                if (flush) begin
                    state_next = md_state_idle;
                end else begin
                    acc_next = is_div_reg ? div_step : mul_step;
                    cnt_next = cnt_reg + 5'd1;
                    if (cnt_reg == MD_LAST_CNT) begin
                        state_next = md_state_done;
                    end
                end
            end

            md_state_done: begin
                // Always return to IDLE; a held start is the same instruction.
                state_next = md_state_idle;
                if (!flush) begin
                    if (!is_div_reg) begin
                        hi_next = prod_fix[63:32];
                        lo_next = prod_fix[31:0];
                    end else if (div0_reg) begin
                        hi_next = rs_raw_reg;
                        lo_next = 32'hFFFF_FFFF;
                    end else begin
                        hi_next = rem_fix;
                        lo_next = quo_fix;
                    end
                end
            end

            default: begin
                state_next = md_state_idle;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= md_state_idle;
            cnt_reg     <= 5'd0;
            acc_reg     <= 64'd0;
            addend_reg  <= 32'd0;
            rs_raw_reg  <= 32'd0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            addend_reg  <= addend_next;
            rs_raw_reg  <= rs_raw_next;
            is_div_reg  <= is_div_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            div0_reg    <= div0_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    // Stall while accepting and while iterating; DONE lets the instruction go.
    assign stall_req = ((state_reg == md_state_idle) & start & ~flush)
                     | ((state_reg == md_state_calc) & ~flush);
    assign busy      = (state_reg != md_state_idle);
    assign hi        = hi_reg;
    assign lo        = lo_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference model: returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        logic [63:0]     p;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (o)
            2'b00: begin
                q   = sa * sb;
                res = q;
            end
            2'b01: begin
                p   = {32'd0, a} * {32'd0, b};
                res = p;
            end
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    // Issue one mul/div starting in the current (IDLE) cycle.
    // flush_at: cycle index (0 = accept cycle, 1..32 = CALC, 33 = DONE) at
    // which flush is raised, or -1 for none. mt_in_calc pulses MTHI/MTLO
    // during CALC. Returns positioned mid-cycle in the following IDLE cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit mt_in_calc);
        logic [63:0] r;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          c;
        int          stall_cnt;
        old_hi    = exp_hi;
        old_lo    = exp_lo;
        start     = 1'b1;
        op        = o;
        rs_val    = a;
        rt_val    = b;
        stall_cnt = 0;
        for (c = 0; c < 40; c++) begin
            hi_we = mt_in_calc && (c == 5);
            lo_we = mt_in_calc && (c == 5);
            wdata = 32'hDEAD_BEEF;
            flush = (c == flush_at);
            #1;
            if (stall_req) stall_cnt++;
            if (c == flush_at) break;
            if (!stall_req) break;
            @(negedge clk);
            #1;
        end
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (flush_at < 0) begin
            check_val("occupancy", 64'(c), 64'd33);
            check_val("stall_cycles", 64'(stall_cnt), 64'd33);
            check_val("done_busy", 64'(busy), 64'd1);
            check_val("done_hi_old", 64'(hi), 64'(old_hi));
            check_val("done_lo_old", 64'(lo), 64'(old_lo));
        end else begin
            check_val("flush_stall", 64'(stall_req), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        if (flush_at < 0) begin
            r      = ref_md(o, a, b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
        end
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_stall", 64'(stall_req), 64'd0);
        check_val("hi", 64'(hi), 64'(exp_hi));
        check_val("lo", 64'(lo), 64'(exp_lo));
        $display("op=%0d a=%h b=%h flush_at=%0d hi=%h lo=%h", o, a, b, flush_at, hi, lo);
    endtask

    // MTHI/MTLO in IDLE; visible right after the edge.
    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
        hi_we = wh;
        lo_we = wl;
        wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (wh) exp_hi = d;
        if (wl) exp_lo = d;
        check_val("mt_hi", 64'(hi), 64'(exp_hi));
        check_val("mt_lo", 64'(lo), 64'(exp_lo));
        $display("mt hi_we=%0d lo_we=%0d data=%h hi=%h lo=%h", wh, wl, d, hi, lo);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = 32'd0;
        rt_val = 32'd0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = 32'd0;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_stall", 64'(stall_req), 64'd0);
        rst = 1'b0;

        // Directed corner cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1, 1'b0);

        // MTHI in IDLE, then MTLO/MTHI during CALC ignored
        mt_write(1'b1, 1'b0, 32'h1234_5678);
        run_op(2'b01, 32'd1000, 32'd3, -1, 1'b1);

        // Flush in CALC cycle 10 and in DONE leave HI/LO untouched
        mt_write(1'b1, 1'b0, 32'h0000_000A);
        mt_write(1'b0, 1'b1, 32'h0000_000B);
        run_op(2'b11, 32'd9, 32'd2, 11, 1'b0);
        run_op(2'b11, 32'd9, 32'd2, 33, 1'b0);

        // Reset in the middle of CALC
        run_op(2'b00, 32'h0000_1234, 32'hFFFF_0001, -1, 1'b0);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd77;
        rt_val = 32'd88;
        repeat (8) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check_val("midrst_hi", 64'(hi), 64'd0);
        check_val("midrst_lo", 64'(lo), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_stall", 64'(stall_req), 64'd0);
        $display("reset mid-CALC hi=%h lo=%h busy=%0d", hi, lo, busy);
        rst    = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        // Back-to-back operations with no idle gap
        run_op(2'b01, 32'd3, 32'd5, -1, 1'b0);
        run_op(2'b01, 32'd4, 32'd6, -1, 1'b0);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op(ro, ra, rb, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
